// File: rtl/instruction_encoder.sv
// Packs I/R/J instruction fields into 32-bit words and queues them in a 4-entry FIFO with byte addresses.
// Optional macro ENC_LEGALITY_CHECK_EN adds opcode legality checks per format.
module instruction_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  ftype,
  input  logic [5:0]  opc,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] iindex,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] addr,
  output logic        illegal,
  output logic [2:0]  count
);

  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [31:0] word;
  logic        bad;
  logic        take;
  logic        push;
  logic        pop;

  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (ftype)
      2'b00: word = {opc, rs, rt, imm};
      2'b01: word = {6'b0, rs, rt, rd, shamt, funct};
      2'b10: word = {opc, iindex};
      default: bad = 1'b1;
    endcase
`ifdef ENC_LEGALITY_CHECK_EN
    case (ftype)
      2'b00: if (opc == 6'b000000 || opc == 6'b000010 || opc == 6'b000011) bad = 1'b1;
      2'b01: if (opc != 6'b000000) bad = 1'b1;
      2'b10: if (opc != 6'b000010 && opc != 6'b000011) bad = 1'b1;
      default: bad = 1'b1;
    endcase
`endif
  end

  // in_ready depends only on occupancy, never on out_ready
  assign in_ready  = (count != 3'd4);
  assign out_valid = (count != 3'd0);
  assign take      = in_valid && in_ready;
  assign push      = take && !bad;
  assign pop       = out_valid && out_ready;
  assign instr     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      addr    <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= take && bad;
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
        addr   <= addr + 32'd4;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
